dff_rr_write_arbiter: RTL and testbench

Round-robin arbiter and sequencer for one shared DATA_W-bit register (a bank of D flip-flops). NUM_REQ requesters compete for write access. The winner holds a grant for a burst of up to MAX_BURST write beats. The block drives the register contents, a per-beat valid strobe and the owner index. It sits between producer blocks and any consumer of the shared register.

---
 rtl/dff_rr_write_arbiter_if.sv | 33 +++
 rtl/dff_rr_write_arbiter.sv | 134 +++++++++++++
 tb/tb_dff_rr_write_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_rr_write_arbiter_if.sv
// Write bus between the producer blocks and the round-robin register arbiter.
//
// Handshake: req[i] is a level-sensitive write-valid from requester i and
// gnt[i] is the registered ready for that requester. A write beat happens at
// a rising edge where the arbiter holds gnt[i]=1 and req[i]=1; the data slice
// req_data[i*DATA_W +: DATA_W] is captured into q at that edge and q_valid
// is high for the following cycle. Dropping req[i] while granted ends the
// burst without a capture. req_last[i] is only meaningful on a beat.
interface dff_rr_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         q;
    logic                      q_valid;
    logic [OW-1:0]             q_owner;

    // Producer side: drives requests and data, observes grant and register.
    modport master (
        output req, req_data, req_last,
        input  gnt, q, q_valid, q_owner
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, req_last,
        output gnt, q, q_valid, q_owner
    );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin arbiter that sequences write bursts from NUM_REQ requesters
// into one shared DATA_W-bit register. One grant at a time, bursts capped at
// MAX_BURST beats, one idle cycle between bursts for re-arbitration.
module dff_rr_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dff_rr_write_arbiter_if.slave   bus,
    output logic                    o_dbg_state
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [DATA_W-1:0]   r_q;
    logic                r_q_valid;
    logic [OW-1:0]       r_q_owner;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last_winner;
    logic [CW-1:0]       r_beat_cnt;

    logic                w_found;
    logic [OW-1:0]       w_winner;
    logic [OW:0]         w_sum;
    logic [OW-1:0]       w_cand;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_own_req;
    logic                w_own_last;
    logic [DATA_W-1:0]   w_own_data;
    logic                w_final;

    // Rotating priority search: first pending request after last_winner, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_winner} + (OW+1)'(k + 1);
            if (w_sum >= (OW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (OW+1)'(NUM_REQ);
            end
            w_cand = w_sum[OW-1:0];
            if (!w_found && bus.req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Select the current owner's request, last flag and data slice.
    always_comb begin
        w_onehot   = '0;
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_onehot[k] = (w_winner == OW'(k));
            if (r_owner == OW'(k)) begin
                w_own_req  = bus.req[k];
                w_own_last = bus.req_last[k];
                w_own_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // A beat ends the burst on req_last or when the beat cap is reached.
    assign w_final = w_own_last || (r_beat_cnt == CW'(MAX_BURST - 1));

    // Arbitration FSM and the shared register; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_q           <= '0;
            r_q_valid     <= 1'b0;
            r_q_owner     <= '0;
            r_owner       <= '0;
            r_beat_cnt    <= '0;
            r_last_winner <= OW'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_q_valid <= 1'b0;
                    if (w_found) begin
                        r_gnt      <= w_onehot;
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_own_req) begin
                        r_q        <= w_own_data;
                        r_q_valid  <= 1'b1;
                        r_q_owner  <= r_owner;
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                        if (w_final) begin
                            r_gnt         <= '0;
                            r_last_winner <= r_owner;
                            r_state       <= S_IDLE;
                        end
                    end else begin
                        // Withdrawal: release the grant without touching q.
                        r_q_valid     <= 1'b0;
                        r_gnt         <= '0;
                        r_last_winner <= r_owner;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.q_owner = r_q_owner;
    assign o_dbg_state = (r_state == S_GRANT);

endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
// Directed bench for the round-robin register write arbiter.
module tb_dff_rr_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
    int   n_checks = 0;
    int   n_pass   = 0;

    dff_rr_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    dff_rr_write_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] r;
        // build up non-reset state first: requester 1 writes 0xC3
        bus.req = 4'b0010; bus.req_last = 4'b0000; set_data(1, 8'hC3);
        step();
        step();
        n_checks++; if (bus.q_owner !== 2'd1) $display("FAIL rst_pre_owner got=%0d exp=1", bus.q_owner); else n_pass++;
        n_checks++; if (bus.q !== 8'hC3) $display("FAIL rst_pre_q got=%h exp=c3", bus.q); else n_pass++;
        // assert reset mid-cycle with random inputs; outputs must clear without an edge
        #3;
        r = 4'($urandom_range(0, 15));
        bus.req = r; bus.req_last = 4'($urandom_range(0, 15)); bus.req_data = 32'($urandom);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.q !== 8'h00) $display("FAIL rst_q got=%h exp=00", bus.q); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL rst_qvalid got=%b exp=0", bus.q_valid); else n_pass++;
        n_checks++; if (bus.q_owner !== 2'd0) $display("FAIL rst_owner got=%0d exp=0", bus.q_owner); else n_pass++;
        n_checks++; if (dbg_state !== 1'b0) $display("FAIL rst_state got=%b exp=0", dbg_state); else n_pass++;
        step();
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rst_held_gnt got=%b exp=0000", bus.gnt); else n_pass++;
        do_reset();
    endtask

    task automatic test_single_burst();
        bus.req = 4'b0010; bus.req_last = 4'b0000; set_data(1, 8'hA1);
        step();
        n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL sb_grant got=%b exp=0010", bus.gnt); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL sb_grant_qvalid got=%b exp=0", bus.q_valid); else n_pass++;
        step();
        n_checks++; if (bus.q !== 8'hA1) $display("FAIL sb_beat1_q got=%h exp=a1", bus.q); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b1) $display("FAIL sb_beat1_qvalid got=%b exp=1", bus.q_valid); else n_pass++;
        n_checks++; if (bus.q_owner !== 2'd1) $display("FAIL sb_beat1_owner got=%0d exp=1", bus.q_owner); else n_pass++;
        n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL sb_beat1_gnt got=%b exp=0010", bus.gnt); else n_pass++;
        set_data(1, 8'hA2); bus.req_last = 4'b0010;
        step();
        n_checks++; if (bus.q !== 8'hA2) $display("FAIL sb_beat2_q got=%h exp=a2", bus.q); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b1) $display("FAIL sb_beat2_qvalid got=%b exp=1", bus.q_valid); else n_pass++;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL sb_end_gnt got=%b exp=0000", bus.gnt); else n_pass++;
        bus.req = 4'b0000; bus.req_last = 4'b0000;
        step();
        n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL sb_idle_qvalid got=%b exp=0", bus.q_valid); else n_pass++;
        n_checks++; if (bus.q !== 8'hA2) $display("FAIL sb_idle_q got=%h exp=a2", bus.q); else n_pass++;
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req = 4'b1111; bus.req_last = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h10 + 8'(i));
        for (int b = 0; b < 5; b++) begin
            int w;
            logic [3:0] eg;
            logic [7:0] eq;
            w  = b % NUM_REQ;
            eg = 4'b0001 << w;
            eq = 8'h10 + 8'(w);
            step();
            n_checks++; if (bus.gnt !== eg) $display("FAIL rot_grant%0d got=%b exp=%b", b, bus.gnt, eg); else n_pass++;
            n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL rot_gap_qvalid%0d got=%b exp=0", b, bus.q_valid); else n_pass++;
            step();
            n_checks++; if (bus.q !== eq) $display("FAIL rot_q%0d got=%h exp=%h", b, bus.q, eq); else n_pass++;
            n_checks++; if (bus.q_owner !== 2'(w)) $display("FAIL rot_owner%0d got=%0d exp=%0d", b, bus.q_owner, w); else n_pass++;
            n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rot_end_gnt%0d got=%b exp=0000", b, bus.gnt); else n_pass++;
        end
        bus.req = 4'b0000; bus.req_last = 4'b0000;
        step();
    endtask

    task automatic test_burst_cap();
        // last winner is 0, so requester 2 wins over pending requester 3
        bus.req = 4'b1100; bus.req_last = 4'b0000;
        set_data(2, 8'h20); set_data(3, 8'h3F);
        step();
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL cap_grant got=%b exp=0100", bus.gnt); else n_pass++;
        for (int b = 0; b < MAX_BURST; b++) begin
            logic [3:0] eg;
            logic [7:0] eq;
            eq = 8'h20 + 8'(b);
            eg = (b < MAX_BURST - 1) ? 4'b0100 : 4'b0000;
            set_data(2, eq);
            step();
            n_checks++; if (bus.q !== eq) $display("FAIL cap_q%0d got=%h exp=%h", b, bus.q, eq); else n_pass++;
            n_checks++; if (bus.q_owner !== 2'd2) $display("FAIL cap_owner%0d got=%0d exp=2", b, bus.q_owner); else n_pass++;
            n_checks++; if (bus.gnt !== eg) $display("FAIL cap_gnt%0d got=%b exp=%b", b, bus.gnt, eg); else n_pass++;
        end
        set_data(2, 8'h99);
        step();
        n_checks++; if (bus.gnt !== 4'b1000) $display("FAIL cap_next_grant got=%b exp=1000", bus.gnt); else n_pass++;
        n_checks++; if (bus.q !== 8'h23) $display("FAIL cap_gap_q got=%h exp=23", bus.q); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL cap_gap_qvalid got=%b exp=0", bus.q_valid); else n_pass++;
        bus.req_last = 4'b1000;
        step();
        n_checks++; if (bus.q !== 8'h3F) $display("FAIL cap_r3_q got=%h exp=3f", bus.q); else n_pass++;
        n_checks++; if (bus.q_owner !== 2'd3) $display("FAIL cap_r3_owner got=%0d exp=3", bus.q_owner); else n_pass++;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL cap_r3_end got=%b exp=0000", bus.gnt); else n_pass++;
        bus.req = 4'b0000; bus.req_last = 4'b0000;
        step();
    endtask

    task automatic test_withdrawal();
        // last winner is 3, so requester 0 wins; requester 1 stays pending
        bus.req = 4'b0011; bus.req_last = 4'b0000;
        set_data(0, 8'h55); set_data(1, 8'h66);
        step();
        n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL wd_grant got=%b exp=0001", bus.gnt); else n_pass++;
        step();
        n_checks++; if (bus.q !== 8'h55) $display("FAIL wd_beat_q got=%h exp=55", bus.q); else n_pass++;
        bus.req = 4'b0010;
        step();
        n_checks++; if (bus.q !== 8'h55) $display("FAIL wd_hold_q got=%h exp=55", bus.q); else n_pass++;
        n_checks++; if (bus.q_valid !== 1'b0) $display("FAIL wd_qvalid got=%b exp=0", bus.q_valid); else n_pass++;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL wd_gnt got=%b exp=0000", bus.gnt); else n_pass++;
        step();
        n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL wd_next_grant got=%b exp=0010", bus.gnt); else n_pass++;
        bus.req = 4'b0000;
        step();
        n_checks++; if (bus.q !== 8'h55) $display("FAIL wd_r1_noq got=%h exp=55", bus.q); else n_pass++;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL wd_r1_gnt got=%b exp=0000", bus.gnt); else n_pass++;
    endtask

    task automatic test_mid_burst_reset();
        // last winner is 1, requester 2 alone
        bus.req = 4'b0100; bus.req_last = 4'b0000; set_data(2, 8'h77);
        step();
        step();
        set_data(2, 8'h78);
        step();
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL mr_pre_gnt got=%b exp=0100", bus.gnt); else n_pass++;
        n_checks++; if (bus.q !== 8'h78) $display("FAIL mr_pre_q got=%h exp=78", bus.q); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL mr_gnt got=%b exp=0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.q !== 8'h00) $display("FAIL mr_q got=%h exp=00", bus.q); else n_pass++;
        n_checks++; if (bus.q_owner !== 2'd0) $display("FAIL mr_owner got=%0d exp=0", bus.q_owner); else n_pass++;
        bus.req = 4'b1111; bus.req_last = 4'b1111;
        #1;
        rst = 1'b0;
        step();
        n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL mr_first_grant got=%b exp=0001", bus.gnt); else n_pass++;
        bus.req = 4'b0000; bus.req_last = 4'b0000;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        do_reset();
        test_reset();
        test_single_burst();
        test_rotation();
        test_burst_cap();
        test_withdrawal();
        test_mid_burst_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
